// File: rtl/nx_stream_pkg.sv
// Shared definitions for the nexus outbound stream: word format, keep codes,
// packer states and the word tagging helper.
// No ports (package).
package nx_stream_pkg;

  localparam int unsigned WORD_WIDTH = 32;
  // Bit 31 of every word flags a control-source message.
  localparam int unsigned TAG_BIT    = 31;

  localparam logic [7:0] KEEP_FULL = 8'hFF;
  localparam logic [7:0] KEEP_HALF = 8'h0F;

  typedef enum logic [1:0] {
    EMPTY,
    PARTIAL,
    FULL
  } state_t;

  // Build a tagged word {is_ctrl, payload}.
  function automatic logic [WORD_WIDTH-1:0] make_word(input logic               is_ctrl,
                                                      input logic [TAG_BIT-1:0] payload);
    return {is_ctrl, payload};
  endfunction

endpackage

// File: rtl/nx_ob_stream_arbiter_if.sv
// Handshake bundle of the outbound stream arbiter: the two message sources
// and the 64-bit AXI4-stream master side.
// Ports: none (signals only).
//   master : arbiter view (sources in, stream out)
//   slave  : environment view (sources out, stream in)
interface nx_ob_stream_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned MSG_WIDTH  = 31
);

  localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 8;

  logic [MSG_WIDTH-1:0]  ctrl_data_i;
  logic                  ctrl_valid_i;
  logic                  ctrl_ready_o;
  logic [MSG_WIDTH-1:0]  mesh_data_i;
  logic                  mesh_valid_i;
  logic                  mesh_ready_o;
  logic [DATA_WIDTH-1:0] outbound_tdata_o;
  logic [KEEP_WIDTH-1:0] outbound_tkeep_o;
  logic [KEEP_WIDTH-1:0] outbound_tstrb_o;
  logic                  outbound_tlast_o;
  logic                  outbound_tvalid_o;
  logic                  outbound_tready_i;

  modport master (
    input  ctrl_data_i, ctrl_valid_i, mesh_data_i, mesh_valid_i, outbound_tready_i,
    output ctrl_ready_o, mesh_ready_o,
    output outbound_tdata_o, outbound_tkeep_o, outbound_tstrb_o,
    output outbound_tlast_o, outbound_tvalid_o
  );

  modport slave (
    output ctrl_data_i, ctrl_valid_i, mesh_data_i, mesh_valid_i, outbound_tready_i,
    input  ctrl_ready_o, mesh_ready_o,
    input  outbound_tdata_o, outbound_tkeep_o, outbound_tstrb_o,
    input  outbound_tlast_o, outbound_tvalid_o
  );

endinterface

// File: rtl/nx_rr_arbiter2.sv
// Two-way round-robin arbiter. A single requester is always granted; on a tie
// the requester not granted last wins. The pointer moves only on accept.
// Ports:
//   clk, rst : clock, async active-high reset (pointer favours req[0])
//   req[1:0] : request vector (bit 0 = ctrl, bit 1 = mesh)
//   accept   : the current grant was consumed this cycle
//   grant    : one-hot grant, combinational from req and pointer
module nx_rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  // 0: req[0] wins a tie, 1: req[1] wins a tie.
  logic prio_q;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = prio_q ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // After granting req[0] the tie goes to req[1], and vice versa.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q <= 1'b0;
    end else if (accept && (grant != 2'b00)) begin
      prio_q <= grant[0];
    end
  end

endmodule

// File: rtl/nx_ob_stream_arbiter.sv
// Outbound stream arbiter: round-robin merges control and mesh messages,
// tags each as {is_ctrl, payload} and packs two words per 64-bit beat (low
// half first). A lone word is flushed as a half beat (tkeep 0x0F) after
// FLUSH_CYCLES idle cycles.
// Ports:
//   clk_i, rst_i : clock, async active-high reset
//   bus          : nx_ob_stream_arbiter_if.master (sources + AXI4-stream out)
//   stat_*_o     : 32-bit wrapping counters, present only with NX_OB_ARB_STATS_EN
// Optional feature macro: NX_OB_ARB_STATS_EN
module nx_ob_stream_arbiter
  import nx_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned MSG_WIDTH    = 31,
  parameter int unsigned FLUSH_CYCLES = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  nx_ob_stream_arbiter_if.master bus
`ifdef NX_OB_ARB_STATS_EN
  ,
  output logic [31:0]            stat_ctrl_words_o,
  output logic [31:0]            stat_mesh_words_o,
  output logic [31:0]            stat_half_beats_o
`endif
);

  localparam int unsigned        TIMER_W    = 8;
  localparam logic [TIMER_W-1:0] FLUSH_LAST = TIMER_W'(FLUSH_CYCLES - 1);

  state_t                  state_q;
  logic [TIMER_W-1:0]      timer_q;
  logic [WORD_WIDTH-1:0]   low_q;
  logic [WORD_WIDTH-1:0]   high_q;
  logic [7:0]              tkeep_q;
  logic                    tvalid_q;

  logic [1:0]              grant;
  logic                    can_take;
  logic                    accept;
  logic [MSG_WIDTH-1:0]    sel_payload;
  logic [WORD_WIDTH-1:0]   in_word;

  nx_rr_arbiter2 u_rr (
    .clk    (clk_i),
    .rst    (rst_i),
    .req    ({bus.mesh_valid_i, bus.ctrl_valid_i}),
    .accept (accept),
    .grant  (grant)
  );

  // A word can be taken unless a held beat is stalled by the downstream.
  assign can_take = (state_q != FULL) || bus.outbound_tready_i;
  assign accept   = (grant != 2'b00) && can_take && !rst_i;

  assign bus.ctrl_ready_o = grant[0] && can_take && !rst_i;
  assign bus.mesh_ready_o = grant[1] && can_take && !rst_i;

  assign sel_payload = grant[0] ? bus.ctrl_data_i : bus.mesh_data_i;
  assign in_word     = make_word(grant[0], TAG_BIT'(sel_payload));

  assign bus.outbound_tdata_o  = DATA_WIDTH'({high_q, low_q});
  assign bus.outbound_tkeep_o  = tkeep_q;
  assign bus.outbound_tstrb_o  = tkeep_q;
  assign bus.outbound_tlast_o  = 1'b1;
  assign bus.outbound_tvalid_o = tvalid_q;

  // Packer FSM: collects words into the beat register and hands it downstream.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= EMPTY;
      timer_q  <= '0;
      low_q    <= '0;
      high_q   <= '0;
      tkeep_q  <= '0;
      tvalid_q <= 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            low_q   <= in_word;
            timer_q <= '0;
            state_q <= PARTIAL;
          end
        end
        PARTIAL: begin
          if (accept) begin
            high_q   <= in_word;
            tkeep_q  <= KEEP_FULL;
            tvalid_q <= 1'b1;
            state_q  <= FULL;
          end else if (timer_q == FLUSH_LAST) begin
            high_q   <= '0;
            tkeep_q  <= KEEP_HALF;
            tvalid_q <= 1'b1;
            state_q  <= FULL;
          end else begin
            timer_q <= timer_q + TIMER_W'(1);
          end
        end
        FULL: begin
          // Retire on handshake; a word taken in the same cycle starts the next beat.
          if (bus.outbound_tready_i) begin
            tvalid_q <= 1'b0;
            if (accept) begin
              low_q   <= in_word;
              timer_q <= '0;
              state_q <= PARTIAL;
            end else begin
              state_q <= EMPTY;
            end
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

`ifdef NX_OB_ARB_STATS_EN
  // Traffic counters, wrapping modulo 2^32.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_ctrl_words_o <= '0;
      stat_mesh_words_o <= '0;
      stat_half_beats_o <= '0;
    end else begin
      if (accept && grant[0]) stat_ctrl_words_o <= stat_ctrl_words_o + 32'd1;
      if (accept && grant[1]) stat_mesh_words_o <= stat_mesh_words_o + 32'd1;
      if ((state_q == FULL) && bus.outbound_tready_i && (tkeep_q == KEEP_HALF)) begin
        stat_half_beats_o <= stat_half_beats_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_nx_ob_stream_arbiter.sv
// Self-checking bench for nx_ob_stream_arbiter: a transaction-level model
// (pending word, held beat, idle count) predicts readies and beats every
// cycle; directed scenarios pin beat contents and accept order to literals.
module tb_nx_ob_stream_arbiter;

  localparam int unsigned FLUSH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nx_ob_stream_arbiter_if bus ();

`ifdef NX_OB_ARB_STATS_EN
  logic [31:0] stat_c, stat_m, stat_h;
`endif

  nx_ob_stream_arbiter #(
    .DATA_WIDTH   (64),
    .MSG_WIDTH    (31),
    .FLUSH_CYCLES (FLUSH)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
`ifdef NX_OB_ARB_STATS_EN
    ,
    .stat_ctrl_words_o (stat_c),
    .stat_mesh_words_o (stat_m),
    .stat_half_beats_o (stat_h)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  bit          m_busy       = 1'b0;
  logic [63:0] m_beat       = '0;
  logic [7:0]  m_keep       = '0;
  bit          m_has_pend   = 1'b0;
  logic [31:0] m_pend       = '0;
  int          m_idle       = 0;
  bit          m_ctrl_first = 1'b1;
  logic [71:0] m_beats[$];
  logic [31:0] m_acc[$];

  function automatic void m_grant(output bit gc, output bit gm);
    bit can;
    can = !m_busy || (bus.outbound_tready_i == 1'b1);
    gc = 1'b0;
    gm = 1'b0;
    if (can) begin
      if (bus.ctrl_valid_i && bus.mesh_valid_i) begin
        gc = m_ctrl_first;
        gm = !m_ctrl_first;
      end else begin
        gc = bus.ctrl_valid_i;
        gm = bus.mesh_valid_i;
      end
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    bit gc, gm;
    logic [31:0] w;
    if (rst) begin
      m_busy = 1'b0; m_has_pend = 1'b0; m_idle = 0; m_ctrl_first = 1'b1;
    end else begin
      m_grant(gc, gm);
      if (m_busy && bus.outbound_tready_i) begin
        m_beats.push_back({m_beat, m_keep});
        m_busy = 1'b0;
      end
      if (gc || gm) begin
        w = gc ? {1'b1, bus.ctrl_data_i} : {1'b0, bus.mesh_data_i};
        m_acc.push_back(w);
        m_ctrl_first = gm;
        if (!m_has_pend) begin
          m_pend = w; m_has_pend = 1'b1; m_idle = 0;
        end else begin
          m_beat = {w, m_pend}; m_keep = 8'hFF; m_busy = 1'b1; m_has_pend = 1'b0;
        end
      end else if (m_has_pend) begin
        if (m_idle == FLUSH - 1) begin
          m_beat = {32'h0, m_pend}; m_keep = 8'h0F; m_busy = 1'b1; m_has_pend = 1'b0;
        end else begin
          m_idle++;
        end
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    bit gc, gm;
    if (rst) begin
      check("rst_readies", 72'({bus.ctrl_ready_o, bus.mesh_ready_o}), 72'(0));
      check("rst_tvalid", 72'(bus.outbound_tvalid_o), 72'(0));
    end else begin
      m_grant(gc, gm);
      check("ctrl_ready", 72'(bus.ctrl_ready_o), 72'(gc));
      check("mesh_ready", 72'(bus.mesh_ready_o), 72'(gm));
      check("tvalid", 72'(bus.outbound_tvalid_o), 72'(m_busy));
      check("tlast", 72'(bus.outbound_tlast_o), 72'(1));
      if (m_busy) begin
        check("tdata", 72'(bus.outbound_tdata_o), 72'(m_beat));
        check("tkeep", 72'(bus.outbound_tkeep_o), 72'(m_keep));
        check("tstrb", 72'(bus.outbound_tstrb_o), 72'(m_keep));
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [30:0] cq[$];
  logic [30:0] mq[$];
  logic [71:0] dut_beats[$];
  logic [31:0] dut_acc[$];

  task automatic drive_heads();
    bus.ctrl_valid_i = (cq.size() != 0);
    bus.ctrl_data_i  = '0;
    if (cq.size() != 0) bus.ctrl_data_i = cq[0];
    bus.mesh_valid_i = (mq.size() != 0);
    bus.mesh_data_i  = '0;
    if (mq.size() != 0) bus.mesh_data_i = mq[0];
  endtask

  task automatic tick();
    bit tc, tm;
    @(negedge clk);
    tc = bus.ctrl_valid_i && bus.ctrl_ready_o;
    tm = bus.mesh_valid_i && bus.mesh_ready_o;
    if (tc) dut_acc.push_back({1'b1, bus.ctrl_data_i});
    if (tm) dut_acc.push_back({1'b0, bus.mesh_data_i});
    if (bus.outbound_tvalid_o && bus.outbound_tready_i)
      dut_beats.push_back({bus.outbound_tdata_o, bus.outbound_tkeep_o});
    @(posedge clk);
    #1;
    if (tc) void'(cq.pop_front());
    if (tm) void'(mq.pop_front());
    drive_heads();
  endtask

  task automatic run_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((cq.size() != 0 || mq.size() != 0 || m_has_pend || m_busy) && n < budget) begin
      tick();
      n++;
    end
    check({name, "_drain"}, 72'(n < budget), 72'(1));
    tick();
  endtask

  task automatic clear_logs();
    dut_beats.delete(); m_beats.delete(); dut_acc.delete(); m_acc.delete();
  endtask

  task automatic expect_beat(input string name, input int i, input logic [71:0] exp);
    logic [71:0] d, m;
    d = 'x;
    m = 'x;
    if (i < dut_beats.size()) d = dut_beats[i];
    if (i < m_beats.size()) m = m_beats[i];
    check({name, "_dut"}, d, exp);
    check({name, "_model"}, m, exp);
  endtask

  task automatic expect_acc(input string name, input int i, input logic [31:0] exp);
    logic [31:0] d, m;
    d = 'x;
    m = 'x;
    if (i < dut_acc.size()) d = dut_acc[i];
    if (i < m_acc.size()) m = m_acc[i];
    check({name, "_dut"}, 72'(d), 72'(exp));
    check({name, "_model"}, 72'(m), 72'(exp));
  endtask

  initial begin
    bus.outbound_tready_i = 1'b0;
    drive_heads();
    repeat (2) @(posedge clk);
    #1;
    check("reset_tvalid", 72'(bus.outbound_tvalid_o), 72'(0));
    check("reset_tdata", 72'(bus.outbound_tdata_o), 72'(0));
    check("reset_tkeep", 72'(bus.outbound_tkeep_o), 72'(0));
    check("reset_readies", 72'({bus.ctrl_ready_o, bus.mesh_ready_o}), 72'(0));
    rst = 1'b0;
    bus.outbound_tready_i = 1'b1;

    // Ctrl only, back-to-back words.
    clear_logs();
    cq.push_back(31'h1); cq.push_back(31'h2); drive_heads();
    run_idle("t1", 20);
    check("t1_nbeats", 72'(dut_beats.size()), 72'(1));
    expect_beat("t1_beat0", 0, {64'h80000002_80000001, 8'hFF});

    // Lone mesh word flushed as a half beat.
    clear_logs();
    mq.push_back(31'h5); drive_heads();
    run_idle("t2", 20);
    check("t2_nbeats", 72'(dut_beats.size()), 72'(1));
    expect_beat("t2_beat0", 0, {64'h00000000_00000005, 8'h0F});

    // Both sources valid: strict alternation starting with ctrl.
    clear_logs();
    cq.push_back(31'hA); cq.push_back(31'hB);
    mq.push_back(31'hC); mq.push_back(31'hD); drive_heads();
    run_idle("t3", 20);
    expect_acc("t3_acc0", 0, 32'h8000000A);
    expect_acc("t3_acc1", 1, 32'h0000000C);
    expect_acc("t3_acc2", 2, 32'h8000000B);
    expect_acc("t3_acc3", 3, 32'h0000000D);
    expect_beat("t3_beat0", 0, {64'h0000000C_8000000A, 8'hFF});
    expect_beat("t3_beat1", 1, {64'h0000000D_8000000B, 8'hFF});

    // Downstream stall while FULL.
    clear_logs();
    bus.outbound_tready_i = 1'b0;
    cq.push_back(31'h11); cq.push_back(31'h12); cq.push_back(31'h13); drive_heads();
    repeat (12) tick();
    check("t4_stall_tvalid", 72'(bus.outbound_tvalid_o), 72'(1));
    check("t4_stall_tdata", 72'(bus.outbound_tdata_o), 72'(64'h80000012_80000011));
    check("t4_stall_ready", 72'({bus.ctrl_ready_o, bus.mesh_ready_o}), 72'(0));
    bus.outbound_tready_i = 1'b1;
    run_idle("t4", 20);
    check("t4_nbeats", 72'(dut_beats.size()), 72'(2));
    expect_beat("t4_beat0", 0, {64'h80000012_80000011, 8'hFF});
    expect_beat("t4_beat1", 1, {64'h00000000_80000013, 8'h0F});

    // Reset while PARTIAL discards the pending word.
    clear_logs();
    mq.push_back(31'h21); drive_heads();
    tick();
    rst = 1'b1;
    tick(); tick();
    check("t5_rst_tvalid", 72'(bus.outbound_tvalid_o), 72'(0));
    check("t5_rst_tkeep", 72'(bus.outbound_tkeep_o), 72'(0));
    rst = 1'b0;
    repeat (8) tick();
    check("t5_no_beat", 72'(dut_beats.size()), 72'(0));
    cq.push_back(31'h31); cq.push_back(31'h32); drive_heads();
    run_idle("t5", 20);
    check("t5_nbeats", 72'(dut_beats.size()), 72'(1));
    expect_beat("t5_beat0", 0, {64'h80000032_80000031, 8'hFF});

    // Mixed traffic after a fresh reset: 3 ctrl, 2 mesh, one timeout.
    clear_logs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cq.push_back(31'h1); cq.push_back(31'h2); cq.push_back(31'h3);
    mq.push_back(31'h4); mq.push_back(31'h5); drive_heads();
    run_idle("t6", 30);
    expect_beat("t6_beat0", 0, {64'h00000004_80000001, 8'hFF});
    expect_beat("t6_beat1", 1, {64'h00000005_80000002, 8'hFF});
    expect_beat("t6_beat2", 2, {64'h00000000_80000003, 8'h0F});
`ifdef NX_OB_ARB_STATS_EN
    check("stat_ctrl", 72'(stat_c), 72'(3));
    check("stat_mesh", 72'(stat_m), 72'(2));
    check("stat_half", 72'(stat_h), 72'(1));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
